// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz VGA timing constants and the shared colour type.
package vga_pkg;

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned RGB_W    = 12;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable; last_c flags the terminal count (N-1),
// i.e. the count that wraps to zero on the next enabled cycle.
module mod_counter
   import vga_pkg::*;
#(
   parameter int unsigned N = H_TOTAL,
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last_c
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign last_c = (cnt_q == W'(N - 1));
   assign cnt    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = last_c ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// VGA pixel prescaler, scan counters and registered sync/colour output stage.
// Sync and colour are captured together on pix_en so both lag col/row by one pixel.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned PIX_DIV  = 4,
   parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_pkg::V_BP
) (
   input  logic             clk,
   input  logic             rst,
   input  rgb_t             rgb_in,
   output logic [CNT_W-1:0] col,
   output logic [CNT_W-1:0] row,
   output logic             pix_en,
   output logic             frame_start,
   output logic             hs,
   output logic             vs,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b
);

   localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
   localparam int unsigned HS_FIN = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
   localparam int unsigned VS_FIN = VS_BEG + V_SYNC;
   localparam int unsigned DIV_W  = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;
   logic             frame_start_q, frame_start_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   rgb_t             rgb_q, rgb_d;
   logic             col_last_c, row_last_c, col_wrap_c;
   logic             active_c, hs_raw_c, vs_raw_c;

   assign col_wrap_c = pix_en_q && col_last_c;

   mod_counter #(.N(H_TOT), .W(CNT_W)) u_col (
      .clk    (clk),
      .rst_n  (rst),
      .en     (pix_en_q),
      .cnt    (col),
      .last_c (col_last_c)
   );

   mod_counter #(.N(V_TOT), .W(CNT_W)) u_row (
      .clk    (clk),
      .rst_n  (rst),
      .en     (col_wrap_c),
      .cnt    (row),
      .last_c (row_last_c)
   );

   // pix_en is looked ahead from div_d so the registered pulse sits on the
   // last clk of the pixel and the counters advance at its trailing edge.
   always_comb begin
      div_d         = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      pix_en_d      = (div_d == DIV_W'(PIX_DIV - 1));
      frame_start_d = pix_en_d && col_last_c && row_last_c;

      active_c = (col < CNT_W'(H_ACTIVE)) && (row < CNT_W'(V_ACTIVE));
      hs_raw_c = !((col >= CNT_W'(HS_BEG)) && (col < CNT_W'(HS_FIN)));
      vs_raw_c = !((row >= CNT_W'(VS_BEG)) && (row < CNT_W'(VS_FIN)));

      hs_d  = hs_q;
      vs_d  = vs_q;
      rgb_d = rgb_q;
      if (pix_en_q) begin
         hs_d  = hs_raw_c;
         vs_d  = vs_raw_c;
         rgb_d = active_c ? rgb_in : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q         <= '0;
         pix_en_q      <= 1'b0;
         frame_start_q <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         rgb_q         <= '0;
      end else begin
         div_q         <= div_d;
         pix_en_q      <= pix_en_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         rgb_q         <= rgb_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign frame_start = frame_start_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign {r, g, b}   = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a shrunken 32x15 raster (16x8 visible,
// hsync cols 20..25, vsync rows 10..11) so a whole frame fits in 1920 clk.
module tb_vga_timing;

   localparam int unsigned PD  = 4;
   localparam int unsigned HA  = 16, HFP = 4, HSW = 6, HBP = 6;
   localparam int unsigned VA  = 8,  VFP = 2, VSW = 2, VBP = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] rgb_in;
   logic [9:0]  col, row;
   logic        pix_en, frame_start, hs, vs;
   logic [3:0]  r, g, b;

   int n_chk, n_pass, cyc;
   int pe_cnt, fs_cnt, hs_lo, vs_lo, lit;

   typedef struct {
      int          t;
      logic [9:0]  col;
      logic [9:0]  row;
      logic        pe;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } vec_t;

   vec_t vecs[22];

   always #5 clk = ~clk;

   vga_timing #(
      .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
   ) dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .col(col), .row(row),
      .pix_en(pix_en), .frame_start(frame_start), .hs(hs), .vs(vs),
      .r(r), .g(g), .b(b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [35:0] snap();
      return {col, row, pix_en, frame_start, hs, vs, r, g, b};
   endfunction

   function automatic logic [35:0] pack(input vec_t v);
      return {v.col, v.row, v.pe, v.fs, v.hs, v.vs, v.rgb};
   endfunction

   // One clk; sample 1 time unit after the edge and accumulate pulse/level counts.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pix_en)      pe_cnt++;
      if (frame_start) fs_cnt++;
      if (!hs)         hs_lo++;
      if (!vs)         vs_lo++;
      if ({r, g, b} != 12'h000) lit++;
   endtask

   localparam logic [35:0] RST_VAL = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      //          t     col  row  pe fs hs vs rgb
      vecs[0]  = '{0,    0,   0,   0, 0, 1, 1, 12'h000};
      vecs[1]  = '{3,    0,   0,   1, 0, 1, 1, 12'h000};
      vecs[2]  = '{4,    1,   0,   0, 0, 1, 1, 12'hFFF};
      vecs[3]  = '{64,   16,  0,   0, 0, 1, 1, 12'hFFF};
      vecs[4]  = '{68,   17,  0,   0, 0, 1, 1, 12'h000};
      vecs[5]  = '{80,   20,  0,   0, 0, 1, 1, 12'h000};
      vecs[6]  = '{84,   21,  0,   0, 0, 0, 1, 12'h000};
      vecs[7]  = '{104,  26,  0,   0, 0, 0, 1, 12'h000};
      vecs[8]  = '{108,  27,  0,   0, 0, 1, 1, 12'h000};
      vecs[9]  = '{127,  31,  0,   1, 0, 1, 1, 12'h000};
      vecs[10] = '{128,  0,   1,   0, 0, 1, 1, 12'h000};
      vecs[11] = '{132,  1,   1,   0, 0, 1, 1, 12'hFFF};
      vecs[12] = '{896,  0,   7,   0, 0, 1, 1, 12'h000};
      vecs[13] = '{900,  1,   7,   0, 0, 1, 1, 12'hFFF};
      vecs[14] = '{1028, 1,   8,   0, 0, 1, 1, 12'h000};
      vecs[15] = '{1280, 0,   10,  0, 0, 1, 1, 12'h000};
      vecs[16] = '{1284, 1,   10,  0, 0, 1, 0, 12'h000};
      vecs[17] = '{1536, 0,   12,  0, 0, 1, 0, 12'h000};
      vecs[18] = '{1540, 1,   12,  0, 0, 1, 1, 12'h000};
      vecs[19] = '{1918, 31,  14,  0, 0, 1, 1, 12'h000};
      vecs[20] = '{1919, 31,  14,  1, 1, 1, 1, 12'h000};
      vecs[21] = '{1920, 0,   0,   0, 0, 1, 1, 12'h000};

      rst    = 1'b0;
      rgb_in = 12'hFFF;
      repeat (3) tick();
      chk("in_reset", 64'(snap()), 64'(RST_VAL));

      rst = 1'b1;
      cyc = 0; pe_cnt = 0; fs_cnt = 0; hs_lo = 0; vs_lo = 0; lit = 0;

      // First frame with constant white input.
      for (int i = 0; i < 22; i++) begin
         while (cyc < vecs[i].t) tick();
         chk($sformatf("vec%0d_t%0d", i, vecs[i].t), 64'(snap()), 64'(pack(vecs[i])));
      end

      chk("pix_en_per_frame", 64'(pe_cnt), 64'(480));
      chk("frame_start_per_frame", 64'(fs_cnt), 64'(1));
      chk("hs_low_clks", 64'(hs_lo), 64'(15 * 24));
      chk("vs_low_clks", 64'(vs_lo), 64'(2 * 128));
      chk("lit_clks", 64'(lit), 64'(HA * VA * PD));

      // Single coloured pixel at col 10 appears one pixel period later.
      rgb_in = 12'h000;
      while (cyc < 1960) tick();
      chk("pre_a5c_col", 64'({col, r, g, b}), 64'({10'd10, 12'h000}));
      rgb_in = 12'hA5C;
      while (cyc < 1964) tick();
      chk("a5c_pins", 64'({col, r, g, b}), 64'({10'd11, 4'hA, 4'h5, 4'hC}));
      rgb_in = 12'h000;
      while (cyc < 1968) tick();
      chk("post_a5c_pins", 64'({r, g, b}), 64'(12'h000));

      // Mid-line reset at (10,3) while the pins show white.
      rgb_in = 12'hFFF;
      while (cyc < 2346) tick();
      chk("pre_reset_pos", 64'({col, row, r, g, b}), 64'({10'd10, 10'd3, 12'hFFF}));
      rst = 1'b0;
      #1;
      chk("async_reset", 64'(snap()), 64'(RST_VAL));
      repeat (3) tick();
      chk("reset_held", 64'(snap()), 64'(RST_VAL));

      rst = 1'b1;
      cyc = 0;
      repeat (3) tick();
      chk("restart_pix_en", 64'(snap()),
          64'({10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000}));
      tick();
      chk("restart_col1", 64'(snap()),
          64'({10'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF}));
      chk("no_partial_frame_start", 64'(fs_cnt), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing and output stage for the 640x480@60 Hz VGA display. It divides the system clock into a pixel enable and generates the `col`/`row` scan position consumed by `render`. It captures `render`'s registered `rgb_out` once per pixel and drives the sync and 4:4:4 colour pins, with sync delayed to stay aligned with the colour path.

## Interface
Parameters:
- `PIX_DIV`, 4: `clk` cycles per pixel (100 MHz → 25 MHz); legal ≥ 2.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rgb_in`  in  12  `{R,G,B}` from `render.rgb_out`, valid 1 `clk` after `col`/`row` change.
- `col`  out  10  horizontal scan counter, 0..H_TOTAL-1.
- `row`  out  10  vertical scan counter, 0..V_TOTAL-1.
- `pix_en`  out  1  one-`clk` pulse on the last `clk` of each pixel period.
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (0,0).
- `hs`, `vs`  out  1 each  sync outputs, active-low.
- `r`, `g`, `b`  out  4 each  colour outputs.

## Operation
- H_TOTAL = 800 (sum of H params). V_TOTAL = 525. Widths are fixed at 10 bits; H_TOTAL and V_TOTAL ≤ 1024 is required.
- Prescaler `div` counts 0..PIX_DIV-1 and wraps. `pix_en` = (`div` == PIX_DIV-1), registered so it aligns with the counter update.
- On `pix_en`:
  - `col` increments. At H_TOTAL-1 it wraps to 0 and `row` increments.
  - `row` wraps from V_TOTAL-1 to 0.
- `frame_start` is asserted on the `pix_en` where `col` = H_TOTAL-1 and `row` = V_TOTAL-1.
- Raw decodes, all from the counters:
  - active = `col` < H_ACTIVE && `row` < V_ACTIVE.
  - hs_raw low for `col` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vs_raw low for `row` in [490,492).
- Output stage, updated only on `pix_en`:
  - `rgb_q` ← `rgb_in`.
  - `hs` ← hs_raw, `vs` ← vs_raw.
  - `{r,g,b}` ← active ? `rgb_in` : 12'h000.
- Blanking is therefore forced black whatever `rgb_in` carries.
- No state machine beyond the counters. Counter roles: `div` is the pixel phase, `col` the horizontal phase, `row` the vertical phase.

## Timing
- Reset values (all asynchronous on `rst` = 0):
  - `div` = 0, `col` = 0, `row` = 0.
  - `pix_en` = 0, `frame_start` = 0.
  - `hs` = 1, `vs` = 1.
  - `r`, `g`, `b` = 0.
- After `rst` rises, the first `pix_en` occurs on the PIX_DIV-th `clk` edge.
- `col`/`row` hold for PIX_DIV `clk` cycles. `render` registers `rgb_in` 1 `clk` later, so `rgb_in` is stable when sampled at `pix_en`. This is why PIX_DIV ≥ 2.
- Latency: the colour for position (c,r) appears on pins one pixel period after `col` = c is presented.
- `hs`/`vs` carry the same one-pixel delay, so sync and colour stay aligned. Pin-level `hs` falls one pixel after `col` reaches 656.
- Simultaneous wraps: the `col` wrap, `row` wrap and `frame_start` occur in the same `clk` cycle.
- Reset mid-line: all state returns to reset values immediately and asynchronously. The scan restarts at (0,0) with no partial `frame_start`.

## Structure
- Package `vga_pkg`:
  - default timing constants H_*/V_*.
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - the 12-bit `rgb_t` typedef.
- One natural sub-module, `mod_counter`: a parameterised modulo-N counter with enable, async active-low reset and a wrap flag. It is instantiated twice, once for `col` and once for `row` (row enable = `pix_en` && col_wrap).
- `div` is a local counter inside `vga_timing`.

## Test plan
- Reset release: `rst` 0→1 → `pix_en` first high at `clk` 4 and `col`=1 after it; `hs`=`vs`=1 and rgb=0 before that.
- Line wrap: run 800×4 = 3200 `clk` → `col`=0, `row`=1; `pix_en` count = 800.
- HSync: measure pin `hs` → low for exactly 96 `pix_en` (384 `clk`), beginning at the `pix_en` after `col`=656; period 3200 `clk`.
- VSync and frame: `vs` low for 2 lines (6400 `clk`); `frame_start` period 800×525×4 = 1,680,000 `clk`.
- Blanking: `rgb_in`=12'hFFF constant → pins 4'hF only while delayed-active, 0 for `col` ≥ 640 or `row` ≥ 480; `rgb_in`=12'hA5C at `col`=10 → pins `r`=A, `g`=5, `b`=C one pixel later.
- Mid-line reset: assert `rst`=0 at `col`=300, `row`=200 for 3 `clk` → all outputs at reset values within the same cycle; after release the scan restarts at (0,0).
